dm_multihart: RTL and testbench

- Second-generation RISC-V debug module (spec 0.13) for up to 8 harts. Serves the DTM through a DMI slave port and the harts' debug ROM/park loop through a bus slave port.
- Adds over the single-hart DM: configurable data count, a per-hart halt/resume/havereset array, an abstract-command FSM with busy/cmderr semantics, abstractauto re-execution and register post-increment.

---
 rtl/dm_multihart.sv | 246 ++++++++++++++++++++++++
 tb/tb_dm_multihart.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dm_multihart.sv
// dm_multihart: RISC-V 0.13 debug module serving up to 8 harts over DMI and a hart-side bus.
// Define DM_HAWINDOW_EN to add hasel and the hart-array window mask.
module dm_multihart #(
  parameter int          NUM_HART   = 4,
  parameter int          DATA_COUNT = 4,
  parameter logic [19:0] BUS_BASE   = 20'h00300
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [NUM_HART-1:0] interrupt,
  output logic                ndmreset,
  input  logic                dmi_valid,
  output logic                dmi_ready,
  input  logic                dmi_write,
  input  logic [8:2]          dmi_addr,
  input  logic [31:0]         dmi_wdata,
  output logic [31:0]         dmi_rdata,
  input  logic                bus_valid,
  output logic                bus_ready,
  input  logic                bus_write,
  input  logic [19:0]         bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DONE} state_t;
  localparam logic [11:0] AE_MASK = 12'((1 << DATA_COUNT) - 1);

  state_t              r_state;
  logic                r_dmactive, r_ndmreset, r_resume, r_dmi_rdy, r_bus_rdy;
  logic [2:0]          r_hartsel, r_cmderr;
  logic [NUM_HART-1:0] r_haltreq, r_halted, r_resack, r_haverst;
  logic [11:0]         r_autoexec;
  logic [31:0]         r_cmd, r_req, r_dmi_rdata, r_bus_rdata;
  logic [31:0]         r_data [DATA_COUNT];

  logic                w_hasel, w_busy, w_dmi_xfer, w_bus_wr, w_cmd_wr, w_trig, w_go;
  logic [NUM_HART-1:0] w_win, w_nwin, w_sel, w_nsel, w_hs_oh, w_bid_oh;
  logic [DATA_COUNT-1:0] w_dmi_doh, w_bus_doh;
  logic [19:0]         w_boff;
  logic [2:0]          w_err, w_kind;
  logic [31:0]         w_cand, w_nreq, w_dmctl, w_dmstat, w_acs, w_dmi_rd, w_bus_rd;

  function automatic logic [NUM_HART-1:0] f_oh(input logic [2:0] h);
    logic [NUM_HART-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_HART; i++) if (h == 3'(i)) m[i] = 1'b1;
    return m;
  endfunction

  // {all, any} of x over the selected set; an empty set reports neither
  function automatic logic [1:0] f_red(input logic [NUM_HART-1:0] x,
                                       input logic [NUM_HART-1:0] s);
    return {(|s) && (&(x | ~s)), |(x & s)};
  endfunction

`ifdef DM_HAWINDOW_EN
  logic                r_hasel;
  logic [NUM_HART-1:0] r_window;
  assign w_hasel = r_hasel;
  assign w_win   = r_window;
  assign w_nwin  = dmi_wdata[26] ? r_window : '0;
`else
  assign w_hasel = 1'b0;
  assign w_win   = '0;
  assign w_nwin  = '0;
`endif

  assign interrupt  = r_haltreq;
  assign ndmreset   = r_ndmreset;
  assign dmi_ready  = r_dmi_rdy;
  assign bus_ready  = r_bus_rdy;
  assign dmi_rdata  = r_dmi_rdata;
  assign bus_rdata  = r_bus_rdata;

  assign w_hs_oh    = f_oh(r_hartsel);
  assign w_sel      = w_hs_oh | (w_hasel ? w_win : '0);
  assign w_nsel     = f_oh(dmi_wdata[18:16]) | w_nwin;
  assign w_bid_oh   = (bus_wdata < 32'(NUM_HART)) ? f_oh(bus_wdata[2:0]) : '0;
  assign w_boff     = bus_addr - BUS_BASE;
  assign w_busy     = r_state != S_IDLE;
  assign w_dmi_xfer = dmi_valid && r_dmi_rdy;
  assign w_bus_wr   = bus_valid && r_bus_rdy && bus_write;
  assign w_cmd_wr   = w_dmi_xfer && dmi_write && dmi_addr == 7'h17;
  assign w_trig     = w_cmd_wr || (w_dmi_xfer && |w_dmi_doh &&
                      (w_busy || |(w_dmi_doh & r_autoexec[DATA_COUNT-1:0])));
  assign w_cand     = w_cmd_wr ? dmi_wdata : r_cmd;
  assign w_kind     = (w_cand[31:24] == 8'd0) ? (w_cand[16] ? 3'd2 : 3'd1)
                                              : (w_cand[16] ? 3'd4 : 3'd3);
  assign w_nreq     = {1'b1, w_kind, r_hartsel, 3'b0, w_cand[21:20], 4'b0, w_cand[15:0]};

  assign w_dmctl  = {5'b0, w_hasel, 7'b0, r_hartsel, 14'b0, r_ndmreset, r_dmactive};
  assign w_dmstat = {12'b0, f_red(r_haverst, w_sel), f_red(r_resack, w_sel),
                     {2{int'(r_hartsel) >= NUM_HART}}, 2'b00,
                     f_red(~r_halted, w_sel), f_red(r_halted, w_sel), 1'b1, 3'b0, 4'd2};
  assign w_acs    = {19'b0, w_busy, 1'b0, r_cmderr, 4'b0, 4'(DATA_COUNT)};

  always_comb begin
    w_dmi_doh = '0;
    w_bus_doh = '0;
    for (int i = 0; i < DATA_COUNT; i++) begin
      if (dmi_addr == 7'(4 + i)) w_dmi_doh[i] = 1'b1;
      if (w_boff == 20'(128 + 4 * i)) w_bus_doh[i] = 1'b1;
    end
  end

  always_comb begin
    w_dmi_rd = '0;
    w_bus_rd = (w_boff == 20'h0) ? r_req : '0;
    for (int i = 0; i < DATA_COUNT; i++) begin
      if (w_dmi_doh[i]) w_dmi_rd = r_data[i];
      if (w_bus_doh[i]) w_bus_rd = r_data[i];
    end
    case (dmi_addr)
      7'h10:   w_dmi_rd = w_dmctl;
      7'h11:   w_dmi_rd = w_dmstat;
      7'h15:   w_dmi_rd = 32'(w_win);
      7'h16:   w_dmi_rd = w_acs;
      7'h17:   w_dmi_rd = r_cmd;
      7'h18:   w_dmi_rd = {20'b0, r_autoexec};
      default: ;
    endcase
  end

  // Command gate: the first failing check wins, a standing cmderr blocks all
  always_comb begin
    w_err = '0;
    w_go  = 1'b0;
    if (w_trig && r_cmderr == 3'd0) begin
      if (w_busy) w_err = 3'd1;
      else if (w_cand[31:24] != 8'd0 && w_cand[31:24] != 8'd2) w_err = 3'd2;
      else if (w_cand[31:24] == 8'd0 && w_cand[17] && !(|(r_halted & w_hs_oh)))
        w_err = 3'd4;
      else w_go = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_dmactive  <= 1'b0;
      r_ndmreset  <= 1'b0;
      r_resume    <= 1'b0;
      r_dmi_rdy   <= 1'b0;
      r_bus_rdy   <= 1'b0;
      r_hartsel   <= '0;
      r_cmderr    <= '0;
      r_haltreq   <= '0;
      r_halted    <= '0;
      r_resack    <= '0;
      r_haverst   <= '0;
      r_autoexec  <= '0;
      r_cmd       <= '0;
      r_req       <= '0;
      r_dmi_rdata <= '0;
      r_bus_rdata <= '0;
      for (int i = 0; i < DATA_COUNT; i++) r_data[i] <= '0;
`ifdef DM_HAWINDOW_EN
      r_hasel     <= 1'b0;
      r_window    <= '0;
`endif
    end else begin
      r_dmi_rdy <= dmi_valid && !r_dmi_rdy;
      r_bus_rdy <= bus_valid && !r_bus_rdy;
      if (dmi_valid && !r_dmi_rdy) r_dmi_rdata <= w_dmi_rd;
      if (bus_valid && !r_bus_rdy) r_bus_rdata <= w_bus_rd;
      if (r_ndmreset) r_haverst <= '1;
      if (r_state == S_DONE) r_state <= S_IDLE;

      if (w_bus_wr) begin
        for (int i = 0; i < DATA_COUNT; i++) if (w_bus_doh[i]) r_data[i] <= bus_wdata;
        if (w_boff == 20'h0 && r_state == S_PEND) begin
          r_state <= S_DONE;
          r_req   <= '0;
          if (!r_resume && r_cmd[19]) begin
            if (r_cmd[31:24] == 8'd0) r_cmd[15:0] <= r_cmd[15:0] + 16'd1;
            else r_data[1] <= r_data[1] + (32'd1 << r_cmd[21:20]);
          end
        end
        if (w_boff == 20'h4) r_halted <= r_halted | w_bid_oh;
        if (w_boff == 20'h8 && |w_bid_oh) begin
          r_halted <= r_halted & ~w_bid_oh;
          r_resack <= r_resack | w_bid_oh;
          r_state  <= S_IDLE;
          r_req    <= '0;
        end
        if (w_boff == 20'hC && r_state == S_PEND) begin
          r_cmderr <= 3'd3;
          r_state  <= S_IDLE;
          r_req    <= '0;
        end
      end

      // DMI is applied after the bus so it wins on shared registers
      if (w_dmi_xfer && dmi_write) begin
        if (!w_busy)
          for (int i = 0; i < DATA_COUNT; i++) if (w_dmi_doh[i]) r_data[i] <= dmi_wdata;
        case (dmi_addr)
          7'h10: begin
            r_dmactive <= dmi_wdata[0];
            r_ndmreset <= dmi_wdata[1];
            if (!dmi_wdata[0]) begin
              r_haltreq  <= '0;
              r_hartsel  <= '0;
              r_cmderr   <= '0;
              r_autoexec <= '0;
              r_state    <= S_IDLE;
              r_req      <= '0;
              r_resume   <= 1'b0;
`ifdef DM_HAWINDOW_EN
              r_hasel    <= 1'b0;
              r_window   <= '0;
`endif
            end else begin
              r_hartsel <= dmi_wdata[18:16];
              r_haltreq <= dmi_wdata[31] ? w_nsel : '0;
`ifdef DM_HAWINDOW_EN
              r_hasel   <= dmi_wdata[26];
`endif
              if (dmi_wdata[28]) r_haverst <= r_haverst & ~w_nsel;
              if (dmi_wdata[30] && r_state == S_IDLE) begin
                r_resack <= r_resack & ~w_nsel;
                r_req    <= {1'b1, 3'd5, dmi_wdata[18:16], 25'b0};
                r_state  <= S_PEND;
                r_resume <= 1'b1;
              end
            end
          end
`ifdef DM_HAWINDOW_EN
          7'h15: r_window <= dmi_wdata[NUM_HART-1:0];
`endif
          7'h16: r_cmderr   <= r_cmderr & ~dmi_wdata[10:8];
          7'h18: r_autoexec <= dmi_wdata[11:0] & AE_MASK;
          default: ;
        endcase
      end

      if (w_err != 3'd0) r_cmderr <= w_err;
      if (w_go) begin
        r_cmd    <= w_cand;
        r_req    <= w_nreq;
        r_state  <= S_PEND;
        r_resume <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dm_multihart.sv
// Directed bench for dm_multihart: DMI/bus read results go through an expectation queue.
module tb_dm_multihart;
  localparam int NH = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NH-1:0] interrupt;
  logic          ndmreset;
  logic          dmi_valid, dmi_ready, dmi_write;
  logic [8:2]    dmi_addr;
  logic [31:0]   dmi_wdata, dmi_rdata;
  logic          bus_valid, bus_ready, bus_write;
  logic [19:0]   bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;

  int          errors = 0;
  int          checks = 0;
  string       q_tag[$];
  logic [31:0] q_exp[$];

  always #5 clk = ~clk;

  dm_multihart #(.NUM_HART(NH), .DATA_COUNT(4), .BUS_BASE(20'h00300)) dut (
    .clk(clk), .resetn(resetn), .interrupt(interrupt), .ndmreset(ndmreset),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dmi_xact(input logic w, input logic [6:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    n = 0;
    dmi_valid = 1'b1; dmi_write = w; dmi_addr = a; dmi_wdata = d;
    do begin @(posedge clk); #1; n++; end while (!dmi_ready && n < 20);
    chk("dmi_ready", 32'(dmi_ready), 32'd1);
    rd = dmi_rdata;
    @(posedge clk); #1;
    dmi_valid = 1'b0; dmi_write = 1'b0;
  endtask

  task automatic bus_xact(input logic w, input logic [19:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    int n;
    n = 0;
    bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
    do begin @(posedge clk); #1; n++; end while (!bus_ready && n < 20);
    chk("bus_ready", 32'(bus_ready), 32'd1);
    rd = bus_rdata;
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] rd;
    dmi_xact(1'b1, a, d, rd);
  endtask

  task automatic dmi_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    dmi_xact(1'b0, a, 32'd0, rd);
    chk(q_tag.pop_front(), rd, q_exp.pop_front());
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_xact(1'b1, a, d, rd);
  endtask

  task automatic bus_rd(input string tag, input logic [19:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    bus_xact(1'b0, a, 32'd0, rd);
    chk(q_tag.pop_front(), rd, q_exp.pop_front());
  endtask

  initial begin
    resetn = 1'b0;
    dmi_valid = 1'b0; dmi_write = 1'b0; dmi_addr = '0; dmi_wdata = '0;
    bus_valid = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_wdata = '0;
    #2;
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("rst_dmi_rdy", 32'(dmi_ready), 32'd0);
    chk("rst_bus_rdy", 32'(bus_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    dmi_rd("rst_acs", 7'h16, 32'h00000004);
    dmi_rd("unmapped", 7'h12, 32'h0);

    // halt hart 2
    dmi_wr(7'h10, 32'h80020001);
    chk("halt_irq", 32'(interrupt), 32'h4);
    bus_wr(20'h00304, 32'd2);
    dmi_rd("halt_dmstatus", 7'h11, 32'h00000382);

    // register read with postincrement on halted hart 2
    dmi_wr(7'h17, 32'h002A1008);
    bus_rd("rr_request", 20'h00300, 32'h94201008);
    dmi_rd("rr_busy", 7'h16, 32'h00001004);
    bus_wr(20'h00380, 32'hCAFE0000);
    bus_wr(20'h00300, 32'd0);
    dmi_rd("rr_idle", 7'h16, 32'h00000004);
    dmi_rd("rr_data0", 7'h04, 32'hCAFE0000);
    dmi_rd("rr_regno", 7'h17, 32'h002A1009);

    // second command while pending
    dmi_wr(7'h17, 32'h002A1008);
    dmi_wr(7'h17, 32'h002A1010);
    dmi_rd("busy_cmderr", 7'h16, 32'h00001104);
    bus_rd("busy_request", 20'h00300, 32'h94201008);
    bus_wr(20'h00300, 32'd0);
    dmi_wr(7'h16, 32'h00000700);
    dmi_rd("busy_clear", 7'h16, 32'h00000004);

    // memory read with postincrement, then autoexec re-issue from data0
    dmi_wr(7'h17, 32'h02280000);
    bus_rd("mem_request", 20'h00300, 32'hB4200000);
    bus_wr(20'h00300, 32'd0);
    dmi_rd("mem_inc1", 7'h05, 32'h00000004);
    dmi_wr(7'h05, 32'h00000100);
    dmi_wr(7'h18, 32'h00000001);
    dmi_rd("auto_data0", 7'h04, 32'hCAFE0000);
    bus_rd("auto_request", 20'h00300, 32'hB4200000);
    dmi_wr(7'h06, 32'h00000055);
    bus_wr(20'h00300, 32'd0);
    dmi_rd("auto_data1", 7'h05, 32'h00000104);
    dmi_rd("auto_busyerr", 7'h16, 32'h00000104);
    dmi_rd("auto_discard", 7'h06, 32'h0);
    dmi_wr(7'h18, 32'h0);
    dmi_wr(7'h16, 32'h00000700);

    // exception while pending, then transfer on a running hart
    dmi_wr(7'h17, 32'h002A1008);
    bus_wr(20'h0030C, 32'd0);
    dmi_rd("exc_cmderr", 7'h16, 32'h00000304);
    dmi_wr(7'h16, 32'h00000700);
    dmi_wr(7'h10, 32'h00010001);
    chk("sel1_irq", 32'(interrupt), 32'h0);
    dmi_wr(7'h17, 32'h00221000);
    dmi_rd("run_cmderr", 7'h16, 32'h00000404);
    dmi_wr(7'h16, 32'h00000700);

    // havereset set by ndmreset, acknowledged for hart 1 only
    dmi_wr(7'h10, 32'h00010003);
    chk("ndmreset", 32'(ndmreset), 32'd1);
    dmi_wr(7'h10, 32'h00010001);
    dmi_rd("hr_set", 7'h11, 32'h000C0C82);
    dmi_wr(7'h10, 32'h10010001);
    dmi_rd("hr_ack", 7'h11, 32'h00000C82);
    dmi_wr(7'h10, 32'h00050001);
    dmi_rd("nonexist", 7'h11, 32'h0000C082);

    // resume hart 2
    dmi_wr(7'h10, 32'h40020001);
    bus_rd("res_request", 20'h00300, 32'hD4000000);
    bus_wr(20'h00308, 32'd2);
    dmi_rd("res_dmstatus", 7'h11, 32'h000F0C82);
    dmi_rd("res_idle", 7'h16, 32'h00000004);

    // reset while a command is pending
    dmi_wr(7'h10, 32'h80020001);
    dmi_wr(7'h17, 32'h02200000);
    dmi_rd("pre_rst_busy", 7'h16, 32'h00001004);
    resetn = 1'b0;
    #1;
    chk("mid_rst_irq", 32'(interrupt), 32'd0);
    chk("mid_rst_rdata", dmi_rdata, 32'd0);
    chk("mid_rst_ndm", 32'(ndmreset), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    dmi_rd("post_rst_acs", 7'h16, 32'h00000004);
    chk("post_rst_irq", 32'(interrupt), 32'd0);
    bus_rd("post_rst_req", 20'h00300, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
